// File: rtl/mdu_pkg.sv
// Shared MDU message layouts, requester IDs and small helpers for the MDU arbiter slice.
package mdu_pkg;

   localparam int unsigned MDU_REQ_NBITS    = 70;
   localparam int unsigned MDU_RESP_NBITS   = 35;
   localparam int unsigned MDU_FUNC_NBITS   = 6;
   localparam int unsigned MDU_OP_NBITS     = 32;
   localparam int unsigned MDU_STATUS_NBITS = 3;

   typedef enum logic {
      REQ_PROC = 1'b0,
      REQ_HOST = 1'b1
   } mdu_req_id_e;

   typedef struct packed {
      logic [MDU_FUNC_NBITS-1:0] func;
      logic [MDU_OP_NBITS-1:0]   op_a;
      logic [MDU_OP_NBITS-1:0]   op_b;
   } mdu_req_msg_t;

   typedef struct packed {
      logic [MDU_STATUS_NBITS-1:0] status;
      logic [MDU_OP_NBITS-1:0]     result;
   } mdu_resp_msg_t;

   function automatic mdu_req_id_e mdu_other_req(input mdu_req_id_e id);
      return (id == REQ_PROC) ? REQ_HOST : REQ_PROC;
   endfunction

   function automatic logic [31:0] mdu_sat_inc32(input logic [31:0] v);
      return (v == '1) ? v : v + 32'd1;
   endfunction

endpackage

// File: rtl/mdu_route_fifo.sv
// Route FIFO: remembers which requester owns each in-flight MDU transaction, oldest at the head.
module mdu_route_fifo
   import mdu_pkg::*;
#(
   parameter int unsigned P_DEPTH = 2
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        push_en,
   input  mdu_req_id_e push_id,
   input  logic        pop_en,
   output mdu_req_id_e head_id,
   output logic        empty,
   output logic        full
);

   localparam int unsigned PTR_W = (P_DEPTH > 1) ? $clog2(P_DEPTH) : 1;
   localparam int unsigned CNT_W = $clog2(P_DEPTH) + 1;

   mdu_req_id_e      mem_q [P_DEPTH];
   mdu_req_id_e      mem_d [P_DEPTH];
   logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             push_ok;
   logic             pop_ok;

   function automatic logic [PTR_W-1:0] ptr_next(input logic [PTR_W-1:0] p);
      return (p == PTR_W'(P_DEPTH - 1)) ? '0 : p + PTR_W'(1);
   endfunction

   assign empty   = (cnt_q == '0);
   assign full    = (cnt_q == CNT_W'(P_DEPTH));
   assign head_id = mem_q[rd_ptr_q];
   // full blocks a push even when a pop happens in the same cycle
   assign push_ok = push_en & ~full;
   assign pop_ok  = pop_en & ~empty;

   always_comb begin
      mem_d    = mem_q;
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      cnt_d    = cnt_q;
      if (push_ok) begin
         mem_d[wr_ptr_q] = push_id;
         wr_ptr_d        = ptr_next(wr_ptr_q);
      end
      if (pop_ok) begin
         rd_ptr_d = ptr_next(rd_ptr_q);
      end
      case ({push_ok, pop_ok})
         2'b10:   cnt_d = cnt_q + CNT_W'(1);
         2'b01:   cnt_d = cnt_q - CNT_W'(1);
         default: cnt_d = cnt_q;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         for (int unsigned i = 0; i < P_DEPTH; i++) begin
            mem_q[i] <= REQ_PROC;
         end
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         cnt_q    <= '0;
      end else begin
         mem_q    <= mem_d;
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         cnt_q    <= cnt_d;
      end
   end

endmodule

// File: rtl/mdu_arbiter.sv
// Shares one in-order MDU between proc and host requesters with round-robin arbitration.
// Optional performance counters are enabled with `define MDU_ARBITER_PERF_EN.
module mdu_arbiter
   import mdu_pkg::*;
#(
   parameter int unsigned P_REQ_NBITS       = MDU_REQ_NBITS,
   parameter int unsigned P_RESP_NBITS      = MDU_RESP_NBITS,
   parameter int unsigned P_MAX_OUTSTANDING = 2
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic                    mdu_host_en,

   input  logic                    proc_mdureq_val,
   output logic                    proc_mdureq_rdy,
   input  logic [P_REQ_NBITS-1:0]  proc_mdureq_msg,

   output logic                    proc_mduresp_val,
   input  logic                    proc_mduresp_rdy,
   output logic [P_RESP_NBITS-1:0] proc_mduresp_msg,

   input  logic                    host_mdureq_val,
   output logic                    host_mdureq_rdy,
   input  logic [P_REQ_NBITS-1:0]  host_mdureq_msg,

   output logic                    host_mduresp_val,
   input  logic                    host_mduresp_rdy,
   output logic [P_RESP_NBITS-1:0] host_mduresp_msg,

   output logic                    mdureq_val,
   input  logic                    mdureq_rdy,
   output logic [P_REQ_NBITS-1:0]  mdureq_msg,

   input  logic                    mduresp_val,
   output logic                    mduresp_rdy,
   input  logic [P_RESP_NBITS-1:0] mduresp_msg
`ifdef MDU_ARBITER_PERF_EN
   ,
   output logic [31:0]             perf_proc_grants,
   output logic [31:0]             perf_host_grants,
   output logic [31:0]             perf_conflict_cycles
`endif
);

   mdu_req_id_e last_grant_q, last_grant_d;
   mdu_req_id_e lock_id_q, lock_id_d;
   logic        lock_q, lock_d;

   logic        run;
   logic        proc_elig;
   logic        host_elig;
   logic        grant_vld;
   mdu_req_id_e grant_id;
   logic        req_open;
   logic        req_xfer;

   logic        fifo_empty;
   logic        fifo_full;
   mdu_req_id_e route_id;
   logic        resp_open;
   logic        resp_xfer;

   // reset is active-low, so a high level means the block is operating
   assign run       = reset;
   assign proc_elig = run & proc_mdureq_val;
   assign host_elig = run & mdu_host_en & host_mdureq_val;

   // A held lock wins only while its owner is still eligible; otherwise normal round-robin.
   always_comb begin
      grant_vld = 1'b0;
      grant_id  = REQ_PROC;
      if (lock_q && (lock_id_q == REQ_PROC) && proc_elig) begin
         grant_vld = 1'b1;
         grant_id  = REQ_PROC;
      end else if (lock_q && (lock_id_q == REQ_HOST) && host_elig) begin
         grant_vld = 1'b1;
         grant_id  = REQ_HOST;
      end else if (proc_elig && host_elig) begin
         grant_vld = 1'b1;
         grant_id  = mdu_other_req(last_grant_q);
      end else if (proc_elig) begin
         grant_vld = 1'b1;
         grant_id  = REQ_PROC;
      end else if (host_elig) begin
         grant_vld = 1'b1;
         grant_id  = REQ_HOST;
      end
   end

   assign req_open        = grant_vld & ~fifo_full;
   assign req_xfer        = req_open & mdureq_rdy;
   assign mdureq_val      = req_open;
   assign mdureq_msg      = (grant_id == REQ_HOST) ? host_mdureq_msg : proc_mdureq_msg;
   assign proc_mdureq_rdy = req_open & mdureq_rdy & (grant_id == REQ_PROC);
   assign host_mdureq_rdy = req_open & mdureq_rdy & (grant_id == REQ_HOST);

   always_comb begin
      last_grant_d = last_grant_q;
      lock_d       = 1'b0;
      lock_id_d    = lock_id_q;
      if (req_xfer) begin
         last_grant_d = grant_id;
      end else if (req_open) begin
         lock_d    = 1'b1;
         lock_id_d = grant_id;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         last_grant_q <= REQ_HOST;
         lock_q       <= 1'b0;
         lock_id_q    <= REQ_PROC;
      end else begin
         last_grant_q <= last_grant_d;
         lock_q       <= lock_d;
         lock_id_q    <= lock_id_d;
      end
   end

   mdu_route_fifo #(
      .P_DEPTH (P_MAX_OUTSTANDING)
   ) u_route_fifo (
      .clk     (clk),
      .reset   (reset),
      .push_en (req_xfer),
      .push_id (grant_id),
      .pop_en  (resp_xfer),
      .head_id (route_id),
      .empty   (fifo_empty),
      .full    (fifo_full)
   );

   assign resp_open        = run & ~fifo_empty;
   assign proc_mduresp_val = resp_open & (route_id == REQ_PROC) & mduresp_val;
   assign host_mduresp_val = resp_open & (route_id == REQ_HOST) & mduresp_val;
   assign mduresp_rdy      = resp_open &
                             ((route_id == REQ_HOST) ? host_mduresp_rdy : proc_mduresp_rdy);
   assign proc_mduresp_msg = mduresp_msg;
   assign host_mduresp_msg = mduresp_msg;
   assign resp_xfer        = mduresp_val & mduresp_rdy;

`ifdef MDU_ARBITER_PERF_EN
   logic [31:0] perf_proc_q, perf_proc_d;
   logic [31:0] perf_host_q, perf_host_d;
   logic [31:0] perf_conf_q, perf_conf_d;

   always_comb begin
      perf_proc_d = perf_proc_q;
      perf_host_d = perf_host_q;
      perf_conf_d = perf_conf_q;
      if (req_xfer && (grant_id == REQ_PROC)) begin
         perf_proc_d = mdu_sat_inc32(perf_proc_q);
      end
      if (req_xfer && (grant_id == REQ_HOST)) begin
         perf_host_d = mdu_sat_inc32(perf_host_q);
      end
      if (proc_elig && host_elig) begin
         perf_conf_d = mdu_sat_inc32(perf_conf_q);
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         perf_proc_q <= '0;
         perf_host_q <= '0;
         perf_conf_q <= '0;
      end else begin
         perf_proc_q <= perf_proc_d;
         perf_host_q <= perf_host_d;
         perf_conf_q <= perf_conf_d;
      end
   end

   assign perf_proc_grants     = perf_proc_q;
   assign perf_host_grants     = perf_host_q;
   assign perf_conflict_cycles = perf_conf_q;
`endif

endmodule

// File: doc/mdu_arbiter.md
MDU_ARBITER -- requirements
Module: mdu_arbiter

Interface
REQ-001 Parameters SHALL be:
- P_REQ_NBITS, default 70, MDU request message width.
- P_RESP_NBITS, default 35, MDU response message width.
- P_MAX_OUTSTANDING, default 2, the maximum number of in-flight MDU transactions (power of 2, at least 1).
REQ-002 Ports SHALL be, clock and reset first:
- clk, in, 1: sole clock.
- reset, in, 1: asynchronous, active-low.
- mdu_host_en, in, 1: host port enable.
- proc_mdureq_val/rdy/msg, in/out/in, 1/1/P_REQ_NBITS: processor request.
- proc_mduresp_val/rdy/msg, out/in/out, 1/1/P_RESP_NBITS: processor response.
- host_mdureq_val/rdy/msg, in/out/in, 1/1/P_REQ_NBITS: host request.
- host_mduresp_val/rdy/msg, out/in/out, 1/1/P_RESP_NBITS: host response.
- mdureq_val/rdy/msg, out/in/out, 1/1/P_REQ_NBITS: to the shared MDU.
- mduresp_val/rdy/msg, in/out/in, 1/1/P_RESP_NBITS: from the shared MDU.

Function
REQ-003 The block SHALL share one in-order MDU between the proc and host requesters; messages pass through unmodified.
REQ-004 A transfer SHALL occur on any port when val and rdy are both high at a rising clk edge.
REQ-005 Host requests SHALL be eligible only when mdu_host_en=1; otherwise host_mdureq_rdy=0.
REQ-006 Arbitration SHALL be round-robin via a 1-bit last_grant register. On contention, the requester not granted last wins. Reset value of last_grant is host, so proc wins the first conflict.
REQ-007 Once mdureq_val is asserted for a requester, grant SHALL lock to it until mdureq transfers, with msg held stable; last_grant updates only on transfer.
REQ-008 Route FIFO:
- Each request transfer SHALL push the granted requester ID (0=proc, 1=host) into a FIFO of depth P_MAX_OUTSTANDING.
- When the FIFO is full, mdureq_val=0 and both requester rdy=0.
REQ-009 Response routing:
- mduresp SHALL go to the requester named at the FIFO head, combinationally: the selected val follows mduresp_val and mduresp_rdy follows the selected rdy.
- A response transfer pops the FIFO.
- The non-selected resp_val SHALL be 0.
REQ-010 mduresp_rdy SHALL be 0 when the FIFO is empty. A response arriving while empty is a protocol error, and the bench asserts on it.
REQ-011 Simultaneous push and pop while full SHALL NOT be allowed; full blocks push regardless of pop. Simultaneous push and pop while neither full nor empty SHALL keep the count unchanged.
REQ-012 FIFO pointers SHALL wrap modulo P_MAX_OUTSTANDING; the count is log2(P)+1 bits.
REQ-013 Deasserting mdu_host_en SHALL NOT affect host transactions already in flight: responses still route to host.
REQ-014 Latency: request path 0 cycles (combinational); response path 0 cycles.

Reset
REQ-015 While reset=0:
- FIFO is empty, last_grant = host, grant lock is cleared.
- All val outputs are 0 and all rdy outputs are 0.
REQ-016 Reset asserted mid-transaction SHALL discard in-flight routing state; the MDU is reset by the same signal.

Configuration
REQ-017 With MDU_ARBITER_PERF_EN defined, the block SHALL add the following outputs, each cleared at reset and saturating at all-ones:
- perf_proc_grants[31:0]: proc request transfers.
- perf_host_grants[31:0]: host request transfers.
- perf_conflict_cycles[31:0]: cycles where both requests are eligible and valid.
REQ-018 Without MDU_ARBITER_PERF_EN, these ports and counters SHALL be absent; function is otherwise identical.

Structure
REQ-019 A shared package mdu_pkg SHALL hold:
- MDU_REQ_NBITS = 70 and MDU_RESP_NBITS = 35.
- Request field layout: func[69:64], op_a[63:32], op_b[31:0].
- Response layout: status[34:32], result[31:0].
- The requester-ID enum (REQ_PROC=0, REQ_HOST=1).
REQ-020 The route FIFO SHALL be one sub-module, mdu_route_fifo (depth parameter, 1-bit data); the arbiter logic lives in mdu_arbiter.

Verification
REQ-021 Proc only, host_en=0, MDU mul 3*5 -> mdureq carries proc msg; response 15 routed to proc_mduresp; host_mduresp_val stays 0.
REQ-022 Both valid on the same cycle after reset -> proc granted first, host second; responses 0x0000000F to proc then 0x00000006 to host, in order.
REQ-023 mdureq_rdy held low 3 cycles during host grant while proc raises val -> grant stays host and msg stays stable; proc is served next.
REQ-024 P_MAX_OUTSTANDING=2 with MDU responses stalled -> after 2 request transfers, proc/host rdy=0 until 1 response pops.
REQ-025 Host request in flight, then mdu_host_en dropped -> host still receives its response; new host requests see rdy=0.
REQ-026 Reset pulled low with 2 outstanding, then released -> all val=0, FIFO empty; next conflict is granted to proc.
